// File: rtl/radar_lane_integrator.sv
// Two-lane non-coherent integrator: sums 5 samples per pixel in a 2-stage pipeline,
// tracks frame boundaries and serializes both lanes through a FIFO onto one output stream.
module radar_lane_integrator #(
   parameter int DATA_WIDTH = 16,
   parameter int SAMPLES    = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [10:0]                      row_idx1,
   input  logic [10:0]                      col_idx1,
   input  logic [10:0]                      row_idx2,
   input  logic [10:0]                      col_idx2,
   input  logic [3:0]                       channel_num,
   input  logic [1:0]                       data_start,
   input  logic [1:0]                       data_end,
   input  logic [DATA_WIDTH*SAMPLES*2-1:0]  pixel_in,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [10:0]                      out_row,
   output logic [10:0]                      out_col,
   output logic [3:0]                       out_channel,
   output logic [DATA_WIDTH+2:0]            out_sum,
   output logic                             out_sof,
   output logic                             out_eof,
   output logic [15:0]                      frame_count,
   output logic                             err_orphan,
   output logic                             err_restart
);

   localparam int SW = DATA_WIDTH + 3;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 11 + 11 + 4 + 1 + 1 + SW;

   typedef enum logic [0:0] {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

   state_t               state_r, state_next_s;
   logic                 accept_s;
   logic [1:0]           keep_s, sof_s, eof_s;
   logic                 orphan_s, restart_s, frame_done_s;
   logic [SW-1:0]        x_s [2][SAMPLES];
   logic [1:0][10:0]     row_s, col_s;

   logic [1:0]           a_v_r;
   logic [1:0][SW-1:0]   a_s01_r, a_s23_r, a_x4_r;
   logic [1:0][10:0]     a_row_r, a_col_r;
   logic [1:0]           a_sof_r, a_eof_r;
   logic [3:0]           a_ch_r;

   logic [1:0]           b_v_r;
   logic [1:0][SW-1:0]   b_sum_r;
   logic [1:0][10:0]     b_row_r, b_col_r;
   logic [1:0]           b_sof_r, b_eof_r;
   logic [3:0]           b_ch_r;

   logic [EW-1:0]        mem_r [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_r, rd_ptr_r, wr2_s;
   logic [CW-1:0]        count_r, count_next_s;
   logic [1:0]           n_wr_s, inflight_next_s;
   logic [CW+1:0]        occ_s;
   logic                 rd_s, ready_next_s;
   logic [EW-1:0]        entry0_s, entry1_s;

   assign accept_s = in_valid & in_ready;
   assign row_s    = {row_idx2, row_idx1};
   assign col_s    = {col_idx2, col_idx1};

   // Frame state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Frame decisions for an accepted beat; an orphan beat carries no frame, so its end bits are ignored.
   always_comb begin
      state_next_s = state_r;
      keep_s       = 2'b00;
      sof_s        = 2'b00;
      eof_s        = 2'b00;
      orphan_s     = 1'b0;
      restart_s    = 1'b0;
      frame_done_s = 1'b0;
      if (accept_s) begin
         if ((state_r == IDLE) && (data_start == 2'b00)) begin
            orphan_s = 1'b1;
         end else begin
            if (data_start != 2'b00) begin
               restart_s = (state_r == IN_FRAME);
               if (data_start[0]) begin
                  keep_s = 2'b11;
                  sof_s  = 2'b01;
               end else begin
                  keep_s = 2'b10;
                  sof_s  = 2'b10;
               end
            end else begin
               keep_s = 2'b11;
            end
            if (data_end[0]) begin
               eof_s        = 2'b01;
               keep_s[1]    = 1'b0;
               sof_s[1]     = 1'b0;
               state_next_s = IDLE;
               frame_done_s = 1'b1;
            end else if (data_end[1]) begin
               eof_s        = 2'b10;
               state_next_s = IDLE;
               frame_done_s = 1'b1;
            end else begin
               state_next_s = IN_FRAME;
            end
         end
      end else begin
         state_next_s = state_r;
      end
   end

   // Zero-extend every sample to the accumulation width.
   always_comb begin
      for (int l = 0; l < 2; l++) begin
         for (int k = 0; k < SAMPLES; k++) begin
            x_s[l][k] = {3'b000, pixel_in[(l*SAMPLES+k)*DATA_WIDTH +: DATA_WIDTH]};
         end
      end
   end

   // Lane valids through both pipeline stages.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_v_r <= 2'b00;
         b_v_r <= 2'b00;
      end else begin
         a_v_r <= keep_s;
         b_v_r <= a_v_r;
      end
   end

   // Pipeline datapath: stage A partial sums, stage B final sum.
   always_ff @(posedge clock) begin
      for (int l = 0; l < 2; l++) begin
         a_s01_r[l] <= x_s[l][0] + x_s[l][1];
         a_s23_r[l] <= x_s[l][2] + x_s[l][3];
         a_x4_r[l]  <= x_s[l][4];
         b_sum_r[l] <= a_s01_r[l] + a_s23_r[l] + a_x4_r[l];
      end
      a_row_r <= row_s;
      a_col_r <= col_s;
      a_sof_r <= sof_s;
      a_eof_r <= eof_s;
      a_ch_r  <= channel_num;
      b_row_r <= a_row_r;
      b_col_r <= a_col_r;
      b_sof_r <= a_sof_r;
      b_eof_r <= a_eof_r;
      b_ch_r  <= a_ch_r;
   end

   assign entry0_s = {b_row_r[0], b_col_r[0], b_ch_r, b_sof_r[0], b_eof_r[0], b_sum_r[0]};
   assign entry1_s = {b_row_r[1], b_col_r[1], b_ch_r, b_sof_r[1], b_eof_r[1], b_sum_r[1]};
   assign n_wr_s   = {1'b0, b_v_r[0]} + {1'b0, b_v_r[1]};
   assign wr2_s    = wr_ptr_r + PW'(b_v_r[0]);
   assign rd_s     = out_valid & out_ready;
   assign count_next_s = count_r + CW'(n_wr_s) - CW'(rd_s);

   // Every in-flight beat is reserved as two entries so the FIFO can never overflow.
   always_comb begin
      inflight_next_s = {1'b0, |keep_s} + {1'b0, |a_v_r};
      occ_s           = (CW+2)'(count_next_s) + (CW+2)'({inflight_next_s, 1'b0});
      ready_next_s    = (occ_s <= (CW+2)'(FIFO_DEPTH - 2));
   end

   // FIFO storage: lane 1 lands before lane 2 when both arrive together.
   always_ff @(posedge clock) begin
      if (b_v_r[0]) begin
         mem_r[wr_ptr_r] <= entry0_s;
      end
      if (b_v_r[1]) begin
         mem_r[wr2_s] <= entry1_s;
      end
   end

   // FIFO pointers, occupancy, flow control, frame counter and error pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         count_r     <= {CW{1'b0}};
         in_ready    <= 1'b0;
         frame_count <= 16'd0;
         err_orphan  <= 1'b0;
         err_restart <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_ptr_r + PW'(n_wr_s);
         rd_ptr_r    <= rd_ptr_r + PW'(rd_s);
         count_r     <= count_next_s;
         in_ready    <= ready_next_s;
         frame_count <= frame_done_s ? frame_count + 16'd1 : frame_count;
         err_orphan  <= orphan_s;
         err_restart <= restart_s;
      end
   end

   assign out_valid = (count_r != {CW{1'b0}});

   // Head fields are forced to zero while the FIFO is empty so stale entries never show.
   always_comb begin
      if (out_valid) begin
         {out_row, out_col, out_channel, out_sof, out_eof, out_sum} = mem_r[rd_ptr_r];
      end else begin
         {out_row, out_col, out_channel, out_sof, out_eof, out_sum} = {EW{1'b0}};
      end
   end

endmodule
